hilo_write_arbiter: RTL and testbench

- Shares the 64-bit HI/LO write path between two producers: A = multiplier/MADD result, B = MTHI/MTLO/divider result.
- Arbitrates with bounded-hold round robin and drives the 2:1 64-bit mux select.
- Registers the winning word into a one-entry output stage with valid/ready toward the HI/LO register write port.
- Latency: 1 cycle from accepted request to Out_Valid.

---
 rtl/hilo_write_arbiter.sv | 128 ++++++++++++
 tb/tb_hilo_write_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hilo_write_arbiter.sv
// Two-requester HI/LO write-path arbiter with a one-entry registered output stage.
// Define HILO_ARB_FIXED_PRI_EN for fixed A-over-B priority instead of bounded-hold round robin.
module hilo_write_arbiter #(
  parameter int unsigned MAX_HOLD = 2,
  parameter int unsigned DATA_W   = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ReqA_Valid,
  input  logic [DATA_W-1:0] ReqA_Data,
  output logic              ReqA_Ready,
  input  logic              ReqB_Valid,
  input  logic [DATA_W-1:0] ReqB_Data,
  output logic              ReqB_Ready,
  output logic              MuxSel,
  output logic              Out_Valid,
  output logic [DATA_W-1:0] Out_Data,
  output logic              Out_Src,
  input  logic              Out_Ready
);

  typedef enum logic [1:0] {StIdle, StHoldA, StHoldB} state_e;

  localparam logic [3:0] MaxHold = 4'(MAX_HOLD);

  state_e            state_q, state_d;
  logic [3:0]        hold_cnt_q, hold_cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_src_q, out_src_d;

  logic load_en;
  logic have_win;
  logic win;

  assign load_en = !out_valid_q || Out_Ready;

  // Winner: 0 = A, 1 = B. have_win implies the winner's Valid is high.
  always_comb begin
    have_win = 1'b0;
    win      = 1'b0;
`ifdef HILO_ARB_FIXED_PRI_EN
    if (ReqA_Valid) begin
      have_win = 1'b1;
      win      = 1'b0;
    end else if (ReqB_Valid) begin
      have_win = 1'b1;
      win      = 1'b1;
    end
`else
    if (state_q == StHoldA && ReqA_Valid && (hold_cnt_q < MaxHold || !ReqB_Valid)) begin
      have_win = 1'b1;
      win      = 1'b0;
    end else if (state_q == StHoldB && ReqB_Valid &&
                 (hold_cnt_q < MaxHold || !ReqA_Valid)) begin
      have_win = 1'b1;
      win      = 1'b1;
    end else if (ReqA_Valid && ReqB_Valid) begin
      have_win = 1'b1;
      win      = ~last_grant_q;
    end else if (ReqA_Valid) begin
      have_win = 1'b1;
      win      = 1'b0;
    end else if (ReqB_Valid) begin
      have_win = 1'b1;
      win      = 1'b1;
    end
`endif
  end

  assign MuxSel     = !Reset && have_win && win;
  assign ReqA_Ready = !Reset && load_en && have_win && !win && ReqA_Valid;
  assign ReqB_Ready = !Reset && load_en && have_win && win && ReqB_Valid;

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    if (load_en) begin
      if (have_win) begin
        out_valid_d = 1'b1;
        out_data_d  = win ? ReqB_Data : ReqA_Data;
        out_src_d   = win;
`ifndef HILO_ARB_FIXED_PRI_EN
        last_grant_d = win;
        if (state_q == (win ? StHoldB : StHoldA)) begin
          if (hold_cnt_q != 4'hf) hold_cnt_d = hold_cnt_q + 4'd1;
        end else begin
          state_d    = win ? StHoldB : StHoldA;
          hold_cnt_d = 4'd1;
        end
`endif
      end else begin
        // Either empty or drained this cycle; nothing replaces it.
        out_valid_d = 1'b0;
        state_d     = StIdle;
        hold_cnt_d  = 4'd0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StIdle;
      hold_cnt_q   <= 4'd0;
      last_grant_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
    end
  end

  assign Out_Valid = out_valid_q;
  assign Out_Data  = out_data_q;
  assign Out_Src   = out_src_q;

endmodule

// File: tb/tb_hilo_write_arbiter.sv
// Directed bench for hilo_write_arbiter (MAX_HOLD=2); checks use immediate assertions.
module tb_hilo_write_arbiter;

  localparam logic [63:0] WA1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] WB1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] WA2 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] WB2 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] WA3 = 64'h5555_5555_5555_5555;
  localparam logic [63:0] WB3 = 64'h6666_6666_6666_6666;
  localparam logic [63:0] WA4 = 64'h7777_7777_7777_7777;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqA_Valid, ReqB_Valid;
  logic [63:0] ReqA_Data, ReqB_Data;
  logic        ReqA_Ready, ReqB_Ready;
  logic        MuxSel;
  logic        Out_Valid;
  logic [63:0] Out_Data;
  logic        Out_Src;
  logic        Out_Ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  hilo_write_arbiter #(
    .MAX_HOLD(2),
    .DATA_W  (64)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ReqA_Valid(ReqA_Valid),
    .ReqA_Data (ReqA_Data),
    .ReqA_Ready(ReqA_Ready),
    .ReqB_Valid(ReqB_Valid),
    .ReqB_Data (ReqB_Data),
    .ReqB_Ready(ReqB_Ready),
    .MuxSel    (MuxSel),
    .Out_Valid (Out_Valid),
    .Out_Data  (Out_Data),
    .Out_Src   (Out_Src),
    .Out_Ready (Out_Ready)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [5:0] order;
    order = 6'b001100;  // bit i = source of beat i; A,A,B,B,A,A
    Reset      = 1'b1;
    ReqA_Valid = 1'b1;
    ReqA_Data  = WA1;
    ReqB_Valid = 1'b1;
    ReqB_Data  = WB1;
    Out_Ready  = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 64'(Out_Valid), 64'd0);
    chk("rst_out_data", Out_Data, 64'd0);
    chk("rst_out_src", 64'(Out_Src), 64'd0);
    chk("rst_ready_a", 64'(ReqA_Ready), 64'd0);
    chk("rst_ready_b", 64'(ReqB_Ready), 64'd0);
    chk("rst_muxsel", 64'(MuxSel), 64'd0);
    Reset = 1'b0;

`ifdef HILO_ARB_FIXED_PRI_EN
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fp_ready_a", 64'(ReqA_Ready), 64'd1);
      chk("fp_ready_b", 64'(ReqB_Ready), 64'd0);
      chk("fp_muxsel", 64'(MuxSel), 64'd0);
      tick();
      chk("fp_out_valid", 64'(Out_Valid), 64'd1);
      chk("fp_out_src", 64'(Out_Src), 64'd0);
      chk("fp_out_data", Out_Data, WA1);
    end
`else
    // Round robin with both requesters valid and a free-running consumer.
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_muxsel", 64'(MuxSel), 64'(order[i]));
      chk("rr_ready_a", 64'(ReqA_Ready), 64'(!order[i]));
      chk("rr_ready_b", 64'(ReqB_Ready), 64'(order[i]));
      tick();
      chk("rr_out_valid", 64'(Out_Valid), 64'd1);
      chk("rr_out_src", 64'(Out_Src), 64'(order[i]));
      chk("rr_out_data", Out_Data, order[i] ? WB1 : WA1);
    end

    // Consumer stall: output word must hold and A must not be accepted.
    ReqB_Valid = 1'b0;
    ReqA_Data  = WA2;
    Out_Ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready_a", 64'(ReqA_Ready), 64'd0);
      tick();
      chk("stall_out_valid", 64'(Out_Valid), 64'd1);
      chk("stall_out_data", Out_Data, WA1);
    end
    Out_Ready = 1'b1;
    #1;
    chk("unstall_ready_a", 64'(ReqA_Ready), 64'd1);
    tick();
    chk("unstall_out_data", Out_Data, WA2);
    chk("unstall_out_valid", 64'(Out_Valid), 64'd1);

    // Lone B: accepted every beat even past the hold bound.
    ReqA_Valid = 1'b0;
    ReqB_Valid = 1'b1;
    ReqB_Data  = WB2;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bonly_ready_b", 64'(ReqB_Ready), 64'd1);
      chk("bonly_muxsel", 64'(MuxSel), 64'd1);
      tick();
      chk("bonly_out_src", 64'(Out_Src), 64'd1);
      chk("bonly_out_data", Out_Data, WB2);
    end
    ReqA_Valid = 1'b1;
    ReqA_Data  = WA3;
    #1;
    chk("a_join_ready_a", 64'(ReqA_Ready), 64'd1);
    chk("a_join_ready_b", 64'(ReqB_Ready), 64'd0);
    chk("a_join_muxsel", 64'(MuxSel), 64'd0);
    tick();
    chk("a_join_out_src", 64'(Out_Src), 64'd0);
    chk("a_join_out_data", Out_Data, WA3);

    // Enter HOLD_B with a pending word, then reset mid-operation.
    ReqA_Valid = 1'b0;
    ReqB_Data  = WB3;
    tick();
    chk("pre_rst_out_src", 64'(Out_Src), 64'd1);
    chk("pre_rst_out_data", Out_Data, WB3);
    Out_Ready  = 1'b0;
    ReqA_Valid = 1'b1;
    ReqA_Data  = WA4;
    Reset      = 1'b1;
    #1;
    chk("mid_rst_ready_a", 64'(ReqA_Ready), 64'd0);
    chk("mid_rst_ready_b", 64'(ReqB_Ready), 64'd0);
    chk("mid_rst_muxsel", 64'(MuxSel), 64'd0);
    tick();
    chk("mid_rst_out_valid", 64'(Out_Valid), 64'd0);
    chk("mid_rst_out_data", Out_Data, 64'd0);
    Reset     = 1'b0;
    Out_Ready = 1'b1;
    #1;
    chk("post_rst_ready_a", 64'(ReqA_Ready), 64'd1);
    chk("post_rst_ready_b", 64'(ReqB_Ready), 64'd0);
    tick();
    chk("post_rst_out_src", 64'(Out_Src), 64'd0);
    chk("post_rst_out_data", Out_Data, WA4);

    // No requests: the last word drains and Out_Valid falls.
    ReqA_Valid = 1'b0;
    ReqB_Valid = 1'b0;
    tick();
    chk("drain_out_valid", 64'(Out_Valid), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
